// File: rtl/exec_hazard_ctrl_if.sv
// exec_hazard_ctrl_if: decode/execute/writeback signals exchanged with the hazard controller
interface exec_hazard_ctrl_if #(
    parameter int NREGS = 16
);
    localparam int IW = $clog2(NREGS);
    logic             id_valid_i;
    logic [IW-1:0]    id_src1_i;
    logic [IW-1:0]    id_src2_i;
    logic             id_src1_en_i;
    logic             id_src2_en_i;
    logic [IW-1:0]    id_dst_i;
    logic             id_wr_en_i;
    logic             id_is_load_i;
    logic             ex_branch_taken_i;
    logic             wb_valid_i;
    logic [IW-1:0]    wb_dst_i;
    logic             mem_wait_i;
    logic             stall_if_o;
    logic             stall_id_o;
    logic             stall_ex_o;
    logic             bubble_ex_o;
    logic             flush_o;
    logic [NREGS-1:0] busy_o;
    logic [1:0]       state_o;

    modport master (
        output id_valid_i, id_src1_i, id_src2_i, id_src1_en_i, id_src2_en_i,
               id_dst_i, id_wr_en_i, id_is_load_i, ex_branch_taken_i,
               wb_valid_i, wb_dst_i, mem_wait_i,
        input  stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_o,
               busy_o, state_o
    );

    modport slave (
        input  id_valid_i, id_src1_i, id_src2_i, id_src1_en_i, id_src2_en_i,
               id_dst_i, id_wr_en_i, id_is_load_i, ex_branch_taken_i,
               wb_valid_i, wb_dst_i, mem_wait_i,
        output stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_o,
               busy_o, state_o
    );
endinterface

// File: rtl/exec_hazard_ctrl.sv
// exec_hazard_ctrl: execute-stage hazard scoreboard, flush sequencer and memory freeze.
// Optional macro EXEC_FORWARD_EN: only load-use stalls (one bubble); scoreboard/WAW cap kept.
module exec_hazard_ctrl #(
    parameter int NREGS        = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    exec_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, FREEZE = 2'd2} state_t;

    localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       fcnt, fcnt_nxt;
    logic             pend, pend_nxt;
    logic [1:0]       cnt [NREGS];
    logic [NREGS-1:0] inc_v, dec_v;
    logic             frz, start, flush, raw, waw, haz, issue;

    // Memory wait dominates everything; a branch seen while frozen is remembered in pend
    assign frz   = bus.mem_wait_i;
    assign start = ~frz & (bus.ex_branch_taken_i | pend);
    assign flush = ~frz & (start | (state == FLUSH));

`ifdef EXEC_FORWARD_EN
    localparam int IW = $clog2(NREGS);
    logic          ld_v;
    logic [IW-1:0] ld_dst;

    assign raw = bus.id_valid_i & ld_v &
                 ((bus.id_src1_en_i & (bus.id_src1_i == ld_dst)) |
                  (bus.id_src2_en_i & (bus.id_src2_i == ld_dst)));

    // Remember a load issued last cycle so its consumer takes exactly one bubble
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_v   <= 1'b0;
            ld_dst <= '0;
        end else if (flush) begin
            ld_v   <= 1'b0;
        end else if (!frz) begin
            ld_v   <= issue & bus.id_is_load_i & bus.id_wr_en_i;
            ld_dst <= bus.id_dst_i;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = bus.id_is_load_i;
    assign raw = bus.id_valid_i &
                 ((bus.id_src1_en_i & (|cnt[bus.id_src1_i])) |
                  (bus.id_src2_en_i & (|cnt[bus.id_src2_i])));
`endif

    assign waw   = bus.id_valid_i & bus.id_wr_en_i & (cnt[bus.id_dst_i] == 2'd3);
    assign haz   = raw | waw;
    assign issue = bus.id_valid_i & ~frz & ~flush & ~haz;
    assign inc_v = (issue & bus.id_wr_en_i) ? (NREGS'(1) << bus.id_dst_i) : '0;
    assign dec_v = bus.wb_valid_i ? (NREGS'(1) << bus.wb_dst_i) : '0;

    // Flush suppresses the hazard stall since decode is being squashed; outputs forced low in reset
    assign bus.stall_if_o  = rst_ni & (frz | (~flush & haz));
    assign bus.stall_id_o  = rst_ni & (frz | (~flush & haz));
    assign bus.stall_ex_o  = rst_ni & frz;
    assign bus.bubble_ex_o = rst_ni & ~frz & ~flush & haz;
    assign bus.flush_o     = rst_ni & flush;
    assign bus.state_o     = state;

    // Busy view: a register is busy while any write to it is in flight
    always_comb begin
        bus.busy_o = '0;
        for (int n = 0; n < NREGS; n++) bus.busy_o[n] = |cnt[n];
    end

    // Scoreboard counters; issue and retire to the same register cancel, retire at zero is dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NREGS; n++) cnt[n] <= '0;
        end else begin
            for (int n = 0; n < NREGS; n++) begin
                if (inc_v[n] & ~dec_v[n]) cnt[n] <= cnt[n] + 2'd1;
                else if (dec_v[n] & ~inc_v[n] & (|cnt[n])) cnt[n] <= cnt[n] - 2'd1;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
            fcnt  <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next state: freeze holds a running flush, a new branch (re)starts it, otherwise count down
    always_comb begin
        state_nxt = RUN;
        fcnt_nxt  = fcnt;
        pend_nxt  = frz & (pend | bus.ex_branch_taken_i);
        if (frz) begin
            state_nxt = (state == FLUSH) ? FLUSH : FREEZE;
        end else if (start) begin
            state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            fcnt_nxt  = FC_LOAD;
        end else if (state == FLUSH) begin
            state_nxt = (fcnt <= 2'd1) ? RUN : FLUSH;
            fcnt_nxt  = fcnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// tb_exec_hazard_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_exec_hazard_ctrl;
    localparam int FC = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exec_hazard_ctrl_if #(.NREGS(16)) bus ();

    exec_hazard_ctrl #(.NREGS(16), .FLUSH_CYCLES(FC)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        bus.id_valid_i = 0; bus.id_src1_i = 0; bus.id_src2_i = 0;
        bus.id_src1_en_i = 0; bus.id_src2_en_i = 0; bus.id_dst_i = 0;
        bus.id_wr_en_i = 0; bus.id_is_load_i = 0; bus.ex_branch_taken_i = 0;
        bus.wb_valid_i = 0; bus.wb_dst_i = 0; bus.mem_wait_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        rst_ni = 0;
        bus.id_valid_i = 1; bus.ex_branch_taken_i = 1; bus.mem_wait_i = 1;
        #1;
        got = {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.bubble_ex_o, bus.flush_o, bus.busy_o, bus.state_o};
        checks++;
        if (got !== 23'd0) begin errors++; $display("FAIL reset_held: outputs=%h want 0", got); end
        do_reset();
        #4;
        got = {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.bubble_ex_o, bus.flush_o, bus.busy_o, bus.state_o};
        checks++;
        if (got !== 23'd0) begin errors++; $display("FAIL reset_release: outputs=%h want 0", got); end
        step();
    endtask

`ifdef EXEC_FORWARD_EN
    task automatic test_raw();
        do_reset();
        bus.id_valid_i = 1; bus.id_wr_en_i = 1; bus.id_is_load_i = 1; bus.id_dst_i = 5;
        #4 checks++;
        if (bus.stall_id_o !== 1'b0) begin errors++; $display("FAIL load_issue: stall_id_o=%b want 0", bus.stall_id_o); end
        step();
        bus.id_wr_en_i = 0; bus.id_is_load_i = 0; bus.id_src1_en_i = 1; bus.id_src1_i = 5;
        #4 checks++;
        if ({bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[5]} !== 3'b111) begin
            errors++; $display("FAIL load_use_bubble: stall/bubble/busy5=%b want 111", {bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[5]});
        end
        step();
        #4 checks++;
        if ({bus.stall_id_o, bus.bubble_ex_o} !== 2'b00) begin
            errors++; $display("FAIL load_use_once: stall/bubble=%b want 00", {bus.stall_id_o, bus.bubble_ex_o});
        end
        step();
        bus.id_src1_en_i = 0; bus.id_wr_en_i = 1; bus.id_dst_i = 6;
        step();
        bus.id_wr_en_i = 0; bus.id_src1_en_i = 1; bus.id_src1_i = 6;
        #4 checks++;
        if ({bus.stall_id_o, bus.bubble_ex_o} !== 2'b00) begin
            errors++; $display("FAIL alu_forward: stall/bubble=%b want 00", {bus.stall_id_o, bus.bubble_ex_o});
        end
        step();
        idle();
    endtask
`else
    task automatic test_raw();
        do_reset();
        bus.id_valid_i = 1; bus.id_wr_en_i = 1; bus.id_dst_i = 3;
        #4 checks++;
        if (bus.stall_id_o !== 1'b0) begin errors++; $display("FAIL raw_issue: stall_id_o=%b want 0", bus.stall_id_o); end
        step();
        bus.id_wr_en_i = 0; bus.id_src1_en_i = 1; bus.id_src1_i = 3;
        #4 checks++;
        if ({bus.stall_if_o, bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[3]} !== 4'b1111) begin
            errors++; $display("FAIL raw_stall: if/id/bubble/busy3=%b want 1111", {bus.stall_if_o, bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[3]});
        end
        step();
        bus.wb_valid_i = 1; bus.wb_dst_i = 3;
        #4 checks++;
        if ({bus.stall_id_o, bus.bubble_ex_o} !== 2'b11) begin
            errors++; $display("FAIL raw_wb_cycle: stall/bubble=%b want 11", {bus.stall_id_o, bus.bubble_ex_o});
        end
        step();
        bus.wb_valid_i = 0;
        #4 checks++;
        if ({bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[3]} !== 3'b000) begin
            errors++; $display("FAIL raw_release: stall/bubble/busy3=%b want 000", {bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[3]});
        end
        step();
        idle();
    endtask
`endif

    task automatic test_flush();
        do_reset();
        bus.ex_branch_taken_i = 1; bus.id_valid_i = 1; bus.id_wr_en_i = 1; bus.id_dst_i = 4;
        #4 checks++;
        if ({bus.flush_o, bus.state_o, bus.stall_id_o, bus.bubble_ex_o} !== 5'b10000) begin
            errors++; $display("FAIL flush_start: flush/state/stall/bubble=%b want 10000", {bus.flush_o, bus.state_o, bus.stall_id_o, bus.bubble_ex_o});
        end
        step();
        bus.ex_branch_taken_i = 0;
        #4 checks++;
        if ({bus.flush_o, bus.state_o, bus.busy_o[4]} !== 4'b1010) begin
            errors++; $display("FAIL flush_hold: flush/state/busy4=%b want 1010", {bus.flush_o, bus.state_o, bus.busy_o[4]});
        end
        step();
        idle();
        #4 checks++;
        if ({bus.flush_o, bus.state_o, bus.busy_o} !== 19'd0) begin
            errors++; $display("FAIL flush_end: flush/state/busy=%h want 0", {bus.flush_o, bus.state_o, bus.busy_o});
        end
        step();
    endtask

    task automatic test_freeze();
        do_reset();
        bus.id_valid_i = 1; bus.id_wr_en_i = 1; bus.id_dst_i = 7;
        step();
        for (int k = 0; k < 4; k++) begin
            bus.mem_wait_i = 1; bus.id_dst_i = 9;
            bus.wb_valid_i = (k == 1); bus.wb_dst_i = 7;
            #4 checks++;
            if ({bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.bubble_ex_o} !== 4'b1110 ||
                bus.state_o !== ((k == 0) ? 2'd0 : 2'd2)) begin
                errors++; $display("FAIL freeze_cycle%0d: stalls=%b state=%0d want 1110 state %0d", k,
                    {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.bubble_ex_o}, bus.state_o, (k == 0) ? 0 : 2);
            end
            step();
        end
        idle();
        #4 checks++;
        if ({bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.busy_o} !== 19'd0 || bus.state_o !== 2'd2) begin
            errors++; $display("FAIL freeze_exit: stalls/busy=%h state=%0d want 0 state 2",
                {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.busy_o}, bus.state_o);
        end
        step();
        #4 checks++;
        if (bus.state_o !== 2'd0) begin errors++; $display("FAIL freeze_run: state=%0d want 0", bus.state_o); end
        step();
    endtask

    task automatic test_waw();
        do_reset();
        bus.id_valid_i = 1; bus.id_wr_en_i = 1; bus.id_dst_i = 2;
        for (int k = 0; k < 3; k++) begin
            #4 checks++;
            if (bus.stall_id_o !== 1'b0) begin errors++; $display("FAIL waw_issue%0d: stall_id_o=%b want 0", k, bus.stall_id_o); end
            step();
        end
        bus.wb_valid_i = 1; bus.wb_dst_i = 2;
        #4 checks++;
        if ({bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[2]} !== 3'b111) begin
            errors++; $display("FAIL waw_cap: stall/bubble/busy2=%b want 111", {bus.stall_id_o, bus.bubble_ex_o, bus.busy_o[2]});
        end
        step();
        #4 checks++;
        if (bus.stall_id_o !== 1'b0) begin errors++; $display("FAIL waw_same_cycle: stall_id_o=%b want 0", bus.stall_id_o); end
        step();
        bus.id_valid_i = 0;
        for (int k = 0; k < 2; k++) begin
            #4 checks++;
            if (bus.busy_o[2] !== 1'b1) begin errors++; $display("FAIL waw_drain%0d: busy2=%b want 1", k, bus.busy_o[2]); end
            step();
        end
        bus.wb_valid_i = 0;
        #4 checks++;
        if (bus.busy_o !== 16'h0) begin errors++; $display("FAIL waw_empty: busy=%h want 0000", bus.busy_o); end
        step();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        bus.id_valid_i = 1; bus.id_wr_en_i = 1;
        for (int r = 4; r < 8; r++) begin
            bus.id_dst_i = 4'(r);
            step();
        end
        idle();
        #4 checks++;
        if (bus.busy_o !== 16'h00F0) begin errors++; $display("FAIL mid_flush_busy: busy=%h want 00f0", bus.busy_o); end
        bus.ex_branch_taken_i = 1;
        step();
        bus.ex_branch_taken_i = 0;
        #4 checks++;
        if ({bus.flush_o, bus.state_o} !== 3'b101) begin
            errors++; $display("FAIL mid_flush_state: flush/state=%b want 101", {bus.flush_o, bus.state_o});
        end
        rst_ni = 0;
        #1 checks++;
        if ({bus.flush_o, bus.state_o, bus.busy_o, bus.stall_id_o} !== 20'd0) begin
            errors++; $display("FAIL mid_flush_reset: flush/state/busy/stall=%h want 0", {bus.flush_o, bus.state_o, bus.busy_o, bus.stall_id_o});
        end
        do_reset();
        step();
    endtask

    task automatic test_random();
        int cnt [16];
        int fl, ld_r, s1, s2, d, w;
        bit pend, frz_st, ld_v, mw, bt, v, e1, e2, we, ld, wv;
        bit raw, waw, haz, fl_o, start, iss;
        logic [4:0]  exp_ctl;
        logic [15:0] exp_busy;
        logic [1:0]  exp_st;
        do_reset();
        foreach (cnt[i]) cnt[i] = 0;
        fl = 0; pend = 0; frz_st = 0; ld_v = 0; ld_r = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v  = $urandom_range(9) < 7;
            s1 = $urandom_range(7); s2 = $urandom_range(7);
            d  = $urandom_range(7); w  = $urandom_range(7);
            e1 = $urandom_range(1) == 1; e2 = $urandom_range(1) == 1;
            we = $urandom_range(9) < 6; ld = $urandom_range(9) < 3;
            wv = $urandom_range(1) == 1;
            mw = $urandom_range(5) == 0; bt = $urandom_range(11) == 0;
            bus.id_valid_i = v; bus.id_src1_i = 4'(s1); bus.id_src2_i = 4'(s2);
            bus.id_src1_en_i = e1; bus.id_src2_en_i = e2; bus.id_dst_i = 4'(d);
            bus.id_wr_en_i = we; bus.id_is_load_i = ld; bus.ex_branch_taken_i = bt;
            bus.wb_valid_i = wv; bus.wb_dst_i = 4'(w); bus.mem_wait_i = mw;
            start = !mw && (bt || pend);
            fl_o  = !mw && (start || fl > 0);
`ifdef EXEC_FORWARD_EN
            raw = v && ld_v && ((e1 && s1 == ld_r) || (e2 && s2 == ld_r));
`else
            raw = v && ((e1 && cnt[s1] > 0) || (e2 && cnt[s2] > 0));
`endif
            waw = v && we && cnt[d] == 3;
            haz = raw || waw;
            exp_ctl = {mw || (!fl_o && haz), mw || (!fl_o && haz), mw, !mw && !fl_o && haz, fl_o};
            foreach (cnt[i]) exp_busy[i] = cnt[i] > 0;
            exp_st = (fl > 0) ? 2'd1 : frz_st ? 2'd2 : 2'd0;
            #4 checks++;
            if ({bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.bubble_ex_o, bus.flush_o} !== exp_ctl) begin
                errors++; $display("FAIL rand_ctl cyc%0d: if/id/ex/bubble/flush=%b want %b", cyc,
                    {bus.stall_if_o, bus.stall_id_o, bus.stall_ex_o, bus.bubble_ex_o, bus.flush_o}, exp_ctl);
            end
            checks++;
            if (bus.busy_o !== exp_busy) begin errors++; $display("FAIL rand_busy cyc%0d: busy=%h want %h", cyc, bus.busy_o, exp_busy); end
            checks++;
            if (bus.state_o !== exp_st) begin errors++; $display("FAIL rand_state cyc%0d: state=%0d want %0d", cyc, bus.state_o, exp_st); end
            iss = v && !mw && !fl_o && !haz;
            if (iss && we && !(wv && w == d)) cnt[d]++;
            if (wv && !(iss && we && w == d) && cnt[w] > 0) cnt[w]--;
`ifdef EXEC_FORWARD_EN
            if (fl_o) ld_v = 0;
            else if (!mw) begin ld_v = iss && ld && we; ld_r = d; end
`endif
            if (mw) begin
                frz_st = (fl == 0);
                pend = bt || pend;
            end else begin
                pend = 0; frz_st = 0;
                if (start) fl = FC - 1;
                else if (fl > 0) fl--;
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_flush();
        test_freeze();
        test_waw();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_hazard_ctrl.md
# exec_hazard_ctrl

Pipeline hazard and sequencing controller for the bexkat1 execute stage. It keeps a per-register scoreboard of in-flight writes and decides each cycle whether the decode→execute handoff proceeds, stalls, or is bubbled. It also squashes fetch/decode after a taken branch or jump resolved in execute, and freezes the pipeline while data memory is busy.

## Interface
Parameters:
- NREGS, 16, architectural register count (index width 4)
- FLUSH_CYCLES, 2, cycles flush_o stays asserted per taken branch (1..3)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode holds a valid instruction
- id_src1_i / id_src2_i  in  4  source register indices
- id_src1_en_i / id_src2_en_i  in  1  source actually read
- id_dst_i  in  4  destination register
- id_wr_en_i  in  1  instruction writes id_dst_i (reg_write != 0)
- id_is_load_i  in  1  instruction is T_LOAD
- ex_branch_taken_i  in  1  execute resolved a taken branch/jump this cycle
- wb_valid_i  in  1  writeback retires a register write this cycle
- wb_dst_i  in  4  register retired
- mem_wait_i  in  1  data memory not ready
- stall_if_o  out  1  hold PC/fetch
- stall_id_o  out  1  hold decode register
- stall_ex_o  out  1  hold execute/memory registers
- bubble_ex_o  out  1  load NOP (ir=0) into execute
- flush_o  out  1  replace fetch/decode contents with NOP
- busy_o  out  16  bit n = scoreboard count of reg n nonzero
- state_o  out  2  FSM state (0 RUN, 1 FLUSH, 2 FREEZE)

## Operation
- Scoreboard: 2-bit counter per register. issue = id_valid_i & ~stall_id_o & ~flush_o & ~stall_ex_o.
- issue & id_wr_en_i: cnt[id_dst_i] +1. wb_valid_i: cnt[wb_dst_i] −1. Both to same register in one cycle: unchanged. Decrement at 0: ignored (counter stays 0).
- WAW cap: id_valid_i & id_wr_en_i & cnt[id_dst_i]==3 → hazard.
- RAW hazard (no forwarding): any enabled source with cnt[src]!=0.
- Hazard → stall_if_o=stall_id_o=1, bubble_ex_o=1; nothing issues.
- FSM:
  - RUN: ex_branch_taken_i → flush_o=1 same cycle, go FLUSH with counter FLUSH_CYCLES−1 (stay RUN if FLUSH_CYCLES==1). mem_wait_i (and no branch) → FREEZE.
  - FLUSH: flush_o=1; count down; at 0 return RUN. mem_wait_i extends FLUSH (counter holds).
  - FREEZE: stall_if_o=stall_id_o=stall_ex_o=1, bubble_ex_o=0, no issue; leave to RUN first cycle mem_wait_i low.
- Priority: mem_wait_i freeze > flush > hazard stall. Flush suppresses hazard stall and bubble (decode is being squashed anyway).
- A taken branch while mem_wait_i is high is sampled: flush begins the cycle after mem_wait_i drops.
- wb_valid_i is always honored, including in FREEZE and FLUSH.

## Timing
- Stall/bubble/flush outputs combinational from inputs and state; same-cycle response.
- Scoreboard update visible the cycle after issue/retire; writeback in cycle N unblocks a dependent in decode at cycle N+1.
- Reset (rst_ni low, any time, mid-stall or mid-flush): counters 0, state RUN, flush counter 0, pending branch cleared; all outputs 0 while held in reset and on first cycle after.

## Configuration
- EXEC_FORWARD_EN defined: RAW hazard only for load-use — enabled source equals dst of a load issued the previous cycle (tracked by 1-cycle ld_v/ld_dst register, cleared by flush/reset, held in FREEZE); exactly one bubble. Scoreboard and WAW cap still maintained.
- Undefined: full scoreboard RAW stall as above.

## Test plan
- Reset release, issue ALU write r3, next cycle decode reads r3 (no forwarding) → stall_id_o=1, bubble_ex_o=1 until cycle after wb_valid_i with wb_dst_i=3; busy_o[3] 1→0.
- EXEC_FORWARD_EN: load to r5 then ALU reading r5 → exactly one bubble; ALU reading r5 after ALU writing r5 → no stall.
- ex_branch_taken_i pulse with FLUSH_CYCLES=2 → flush_o high 2 cycles, state_o 0→1→0, no scoreboard increment for squashed instr.
- mem_wait_i high 4 cycles with wb_valid_i for r7 in cycle 2 → all stalls high 4 cycles, busy_o[7] clears, state_o=2 then 0.
- Three issued writers to r2, fourth decode writes r2 → stall; simultaneous issue+retire on r2 leaves count unchanged.
- rst_ni low mid-FLUSH with busy_o=16'h00F0 → busy_o=0, flush_o=0, state_o=0 immediately.
